// File: rtl/conv_layer_ctrl.sv
// Purpose : sequences one valid-padding, stride-1 convolution layer: walks every output pixel,
//           issues input/weight read indices, strobes the MAC and writes each finished pixel.
// Latency : TAPS+RD_LAT+2 cycles per pixel; compute_done one cycle after the last pixel write.
// Backpr. : none; start is accepted only in IDLE with inmem_wantwrite low, otherwise dropped.
//
// Ports:
//   clk, reset (sync, active-low)      - clock and reset
//   compute_start, inmem_wantwrite     - scheduler start request / input-memory fill in progress
//   compute_done, busy                 - completion pulse / run in progress (start..done)
//   in_index[2:0] {ch,row,col}, w_index - input and weight memory read indices
//   mac_clear, mac_en                  - accumulator clear / accumulate read data
//   out_we, out_index[2:0] {och,row,col} - output memory write strobe and address
module conv_layer_ctrl #(
    parameter int NUM_INPUT  = 16,
    parameter int INPUT_DIM  = 13,
    parameter int NUM_OUTPUT = 32,
    parameter int KERNEL_DIM = 3,
    parameter int RD_LAT     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             compute_start,
    input  logic             inmem_wantwrite,
    output logic             compute_done,
    output logic             busy,
    output logic [2:0][15:0] in_index,
    output logic [15:0]      w_index,
    output logic             mac_clear,
    output logic             mac_en,
    output logic             out_we,
    output logic [2:0][15:0] out_index
);

    localparam int OUTPUT_DIM = INPUT_DIM - KERNEL_DIM + 1;
    localparam int TAPS       = NUM_INPUT * KERNEL_DIM * KERNEL_DIM;

    localparam logic [15:0] KMAX   = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] CMAX   = 16'(NUM_INPUT - 1);
    localparam logic [15:0] PMAX   = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0] OMAX   = 16'(NUM_OUTPUT - 1);
    localparam logic [15:0] TAPS16 = 16'(TAPS);
    localparam logic [2:0]  DRLAST = 3'(RD_LAT - 1);

    // Weight indices of all output channels must fit the 16-bit index.
    if (NUM_OUTPUT * TAPS > 65536) begin : g_param_err
        $error("conv_layer_ctrl: NUM_OUTPUT*TAPS exceeds 65536");
    end
    if (RD_LAT < 0 || RD_LAT > 4) begin : g_lat_err
        $error("conv_layer_ctrl: RD_LAT must be 0..4");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t           state_q;
    logic [15:0]      kc_q, kr_q, c_q;        // tap counters
    logic [15:0]      oc_q, row_q, o_q;       // output pixel counters
    logic [15:0]      wbase_q;                // o_q*TAPS, first weight of this output channel
    logic [2:0]       drain_q;
    logic             issue_q;                // a read is being issued this cycle
    logic             done_q, busy_q, clr_q, we_q;
    logic [2:0][15:0] in_idx_q, out_idx_q;
    logic [15:0]      w_q;

    logic [15:0] kc_d, kr_d, c_d, oc_d, row_d, o_d, wbase_d;
    logic        last_tap, last_pix;

    // Next tap and next pixel; kc fastest then kr then c, and oc fastest then row then o.
    always_comb begin
        kc_d = kc_q + 16'd1;
        kr_d = kr_q;
        c_d  = c_q;
        if (kc_q == KMAX) begin
            kc_d = '0;
            kr_d = kr_q + 16'd1;
            if (kr_q == KMAX) begin
                kr_d = '0;
                c_d  = c_q + 16'd1;
            end
        end
        last_tap = (c_q == CMAX) && (kr_q == KMAX) && (kc_q == KMAX);

        oc_d    = oc_q + 16'd1;
        row_d   = row_q;
        o_d     = o_q;
        wbase_d = wbase_q;
        if (oc_q == PMAX) begin
            oc_d  = '0;
            row_d = row_q + 16'd1;
            if (row_q == PMAX) begin
                row_d   = '0;
                o_d     = o_q + 16'd1;
                wbase_d = wbase_q + TAPS16;
            end
        end
        last_pix = (o_q == OMAX) && (row_q == PMAX) && (oc_q == PMAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            kc_q      <= '0;
            kr_q      <= '0;
            c_q       <= '0;
            oc_q      <= '0;
            row_q     <= '0;
            o_q       <= '0;
            wbase_q   <= '0;
            drain_q   <= '0;
            issue_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            clr_q     <= 1'b0;
            we_q      <= 1'b0;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            w_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (compute_start && !inmem_wantwrite) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                        kc_q    <= '0;
                        kr_q    <= '0;
                        c_q     <= '0;
                    end
                end
                S_CLEAR: begin
                    // Present tap (0,0,0) of the current pixel in the first ACCUM cycle.
                    clr_q       <= 1'b0;
                    issue_q     <= 1'b1;
                    in_idx_q[2] <= '0;
                    in_idx_q[1] <= row_q;
                    in_idx_q[0] <= oc_q;
                    w_q         <= wbase_q;
                    state_q     <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (last_tap) begin
                        issue_q <= 1'b0;
                        drain_q <= '0;
                        if (RD_LAT == 0) begin
                            state_q   <= S_WRITE;
                            we_q      <= 1'b1;
                            out_idx_q <= {o_q, row_q, oc_q};
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        kc_q        <= kc_d;
                        kr_q        <= kr_d;
                        c_q         <= c_d;
                        in_idx_q[2] <= c_d;
                        in_idx_q[1] <= row_q + kr_d;
                        in_idx_q[0] <= oc_q + kc_d;
                        // Taps are walked in flat weight order, so the weight index just counts.
                        w_q         <= w_q + 16'd1;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 3'd1;
                    if (drain_q == DRLAST) begin
                        state_q   <= S_WRITE;
                        we_q      <= 1'b1;
                        out_idx_q <= {o_q, row_q, oc_q};
                    end
                end
                S_WRITE: begin
                    we_q <= 1'b0;
                    if (last_pix) begin
                        oc_q    <= '0;
                        row_q   <= '0;
                        o_q     <= '0;
                        wbase_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        oc_q    <= oc_d;
                        row_q   <= row_d;
                        o_q     <= o_d;
                        wbase_q <= wbase_d;
                        clr_q   <= 1'b1;
                        kc_q    <= '0;
                        kr_q    <= '0;
                        c_q     <= '0;
                        state_q <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    in_idx_q  <= '0;
                    out_idx_q <= '0;
                    w_q       <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // mac_en follows the issue strobe by the memory read latency.
    if (RD_LAT == 0) begin : g_nodly
        assign mac_en = issue_q;
    end else begin : g_dly
        logic [RD_LAT-1:0] dly_q;
        if (RD_LAT == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!reset) dly_q <= '0;
                else        dly_q <= issue_q;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (!reset) dly_q <= '0;
                else        dly_q <= {dly_q[RD_LAT-2:0], issue_q};
            end
        end
        assign mac_en = dly_q[RD_LAT-1];
    end

    assign compute_done = done_q;
    assign busy         = busy_q;
    assign mac_clear    = clr_q;
    assign out_we       = we_q;
    assign in_index     = in_idx_q;
    assign out_index    = out_idx_q;
    assign w_index      = w_q;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Purpose : directed check of conv_layer_ctrl in a small configuration, RD_LAT=1 and RD_LAT=0
//           instances sharing one stimulus.
// Latency : expected cycles are hand-computed, counted from the start-accepting edge.
// Backpr. : n/a.
module tb_conv_layer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, compute_start, inmem_wantwrite;

    logic             done1, busy1, clr1, en1, we1;
    logic [2:0][15:0] ii1, oi1;
    logic [15:0]      w1;
    logic             done0, busy0, clr0, en0, we0;
    logic [2:0][15:0] ii0, oi0;
    logic [15:0]      w0;

    conv_layer_ctrl #(.NUM_INPUT(1), .INPUT_DIM(4), .NUM_OUTPUT(2), .KERNEL_DIM(3), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .compute_start(compute_start), .inmem_wantwrite(inmem_wantwrite),
        .compute_done(done1), .busy(busy1), .in_index(ii1), .w_index(w1),
        .mac_clear(clr1), .mac_en(en1), .out_we(we1), .out_index(oi1));

    conv_layer_ctrl #(.NUM_INPUT(1), .INPUT_DIM(4), .NUM_OUTPUT(2), .KERNEL_DIM(3), .RD_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .compute_start(compute_start), .inmem_wantwrite(inmem_wantwrite),
        .compute_done(done0), .busy(busy0), .in_index(ii0), .w_index(w0),
        .mac_clear(clr0), .mac_en(en0), .out_we(we0), .out_index(oi0));

    typedef struct {
        int cyc1;   // out_we cycle, RD_LAT=1 (12 cycles per pixel)
        int cyc0;   // out_we cycle, RD_LAT=0 (11 cycles per pixel)
        int ch;
        int row;
        int col;
    } wr_vec_t;

    typedef struct {
        int col;
        int row;
        int w;
    } tap_vec_t;

    wr_vec_t  wr_tab[8];
    tap_vec_t tap_tab[9];

    int n_vec = 0;
    int n_mis = 0;

    int          n_we1, n_we0, n_en1, n_en0, n_done1, n_done0, done1_cyc, done0_cyc;
    int          n_clr1, n_busy1, first_en1, last_en1;
    int          we1_cyc[16], we0_cyc[16], clr1_cyc[16];
    logic [47:0] we1_idx[16], we0_idx[16];
    logic [15:0] tcol[9], trow[9], tch[9], tw[9];
    logic        busy1_h[0:127], clr1_h[0:127];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        n_we1 = 0; n_we0 = 0; n_en1 = 0; n_en0 = 0; n_done1 = 0; n_done0 = 0;
        done1_cyc = -1; done0_cyc = -1; n_clr1 = 0; n_busy1 = 0;
        first_en1 = -1; last_en1 = -1;
        for (int i = 0; i < 128; i++) begin
            busy1_h[i] = 1'b0;
            clr1_h[i]  = 1'b0;
        end
    endtask

    // Steps ncyc cycles, sampling both DUTs on the falling edge. Cycle k is the k-th cycle
    // after the start-accepting edge. pulse_at>0: extra start pulse plus a wantwrite blip.
    // abort_at>0: reset pulse in that cycle, outputs checked to be zero in the next one.
    task automatic run_cycles(input int ncyc, input int pulse_at, input int abort_at);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k < 128) begin
                busy1_h[k] = busy1;
                clr1_h[k]  = clr1;
            end
            if (we1) begin
                if (n_we1 < 16) begin
                    we1_cyc[n_we1] = k;
                    we1_idx[n_we1] = {oi1[2], oi1[1], oi1[0]};
                end
                n_we1++;
            end
            if (we0) begin
                if (n_we0 < 16) begin
                    we0_cyc[n_we0] = k;
                    we0_idx[n_we0] = {oi0[2], oi0[1], oi0[0]};
                end
                n_we0++;
            end
            if (en1) begin
                n_en1++;
                if (first_en1 < 0) first_en1 = k;
                if (k <= 12) last_en1 = k;
            end
            if (en0) n_en0++;
            if (done1) begin n_done1++; done1_cyc = k; end
            if (done0) begin n_done0++; done0_cyc = k; end
            if (clr1) begin
                if (n_clr1 < 16) clr1_cyc[n_clr1] = k;
                n_clr1++;
            end
            if (busy1) n_busy1++;
            if (k >= 86 && k <= 94) begin
                tcol[k-86] = ii1[0];
                trow[k-86] = ii1[1];
                tch[k-86]  = ii1[2];
                tw[k-86]   = w1;
            end
            if (pulse_at > 0) begin
                if (k == pulse_at) begin
                    compute_start   = 1'b1;
                    inmem_wantwrite = 1'b1;
                end else if (k == pulse_at + 1) begin
                    compute_start = 1'b0;
                end else if (k == pulse_at + 3) begin
                    inmem_wantwrite = 1'b0;
                end
            end
            if (abort_at > 0) begin
                if (k == abort_at) reset = 1'b0;
                if (k == abort_at + 1) begin
                    chk("abort_ctrl1", {59'd0, busy1, done1, clr1, en1, we1}, 64'd0);
                    chk("abort_idx1", {63'd0, |{ii1, w1, oi1}}, 64'd0);
                    chk("abort_ctrl0", {59'd0, busy0, done0, clr0, en0, we0}, 64'd0);
                    chk("abort_idx0", {63'd0, |{ii0, w0, oi0}}, 64'd0);
                    reset = 1'b1;
                end
            end
        end
    endtask

    task automatic start_pulse();
        compute_start = 1'b1;
        @(posedge clk);
        #1 compute_start = 1'b0;
    endtask

    initial begin
        wr_tab = '{
            '{12, 11, 0, 0, 0}, '{24, 22, 0, 0, 1}, '{36, 33, 0, 1, 0}, '{48, 44, 0, 1, 1},
            '{60, 55, 1, 0, 0}, '{72, 66, 1, 0, 1}, '{84, 77, 1, 1, 0}, '{96, 88, 1, 1, 1}
        };
        // Pixel (col1,row1,ch1): input window rows/cols 1..3, weights of output channel 1.
        tap_tab = '{
            '{1, 1, 9}, '{2, 1, 10}, '{3, 1, 11},
            '{1, 2, 12}, '{2, 2, 13}, '{3, 2, 14},
            '{1, 3, 15}, '{2, 3, 16}, '{3, 3, 17}
        };

        reset = 1'b0;
        compute_start = 1'b0;
        inmem_wantwrite = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl1", {59'd0, busy1, done1, clr1, en1, we1}, 64'd0);
        chk("rst_idx1", {63'd0, |{ii1, w1, oi1}}, 64'd0);
        chk("rst_ctrl0", {59'd0, busy0, done0, clr0, en0, we0}, 64'd0);
        chk("rst_idx0", {63'd0, |{ii0, w0, oi0}}, 64'd0);
        reset = 1'b1;

        // Start while the input memory is being filled is dropped.
        clear_rec();
        inmem_wantwrite = 1'b1;
        compute_start = 1'b1;
        run_cycles(4, 0, 0);
        compute_start = 1'b0;
        inmem_wantwrite = 1'b0;
        run_cycles(10, 0, 0);
        chk("blocked_busy1", n_busy1, 0);
        chk("blocked_clr1", n_clr1, 0);
        chk("blocked_en0", n_en0, 0);

        // Full run with an ignored start pulse and a wantwrite blip during ACCUM.
        clear_rec();
        start_pulse();
        run_cycles(110, 5, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("we1_cyc[%0d]", i), we1_cyc[i], wr_tab[i].cyc1);
            chk($sformatf("we1_idx[%0d]", i), {16'd0, we1_idx[i]},
                {16'd0, 16'(wr_tab[i].ch), 16'(wr_tab[i].row), 16'(wr_tab[i].col)});
            chk($sformatf("we0_cyc[%0d]", i), we0_cyc[i], wr_tab[i].cyc0);
            chk($sformatf("we0_idx[%0d]", i), {16'd0, we0_idx[i]},
                {16'd0, 16'(wr_tab[i].ch), 16'(wr_tab[i].row), 16'(wr_tab[i].col)});
            chk($sformatf("clr1_cyc[%0d]", i), clr1_cyc[i], wr_tab[i].cyc1 - 11);
        end
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("tap_col[%0d]", t), tcol[t], tap_tab[t].col);
            chk($sformatf("tap_row[%0d]", t), trow[t], tap_tab[t].row);
            chk($sformatf("tap_ch[%0d]", t), tch[t], 0);
            chk($sformatf("tap_w[%0d]", t), tw[t], tap_tab[t].w);
        end
        chk("n_we1", n_we1, 8);
        chk("n_we0", n_we0, 8);
        chk("n_clr1", n_clr1, 8);
        chk("n_en1", n_en1, 72);
        chk("n_en0", n_en0, 72);
        chk("first_en1", first_en1, 3);
        chk("last_en1_pix0", last_en1, 11);
        chk("done1_cyc", done1_cyc, 97);
        chk("done0_cyc", done0_cyc, 89);
        chk("n_done1", n_done1, 1);
        chk("n_done0", n_done0, 1);
        chk("busy1_c1", busy1_h[1], 1);
        chk("busy1_c97", busy1_h[97], 1);
        chk("busy1_c98", busy1_h[98], 0);

        // Reset during the 3rd pixel's ACCUM aborts without compute_done.
        clear_rec();
        start_pulse();
        run_cycles(110, 0, 28);
        chk("abort_done1", n_done1, 0);
        chk("abort_done0", n_done0, 0);
        chk("abort_we1", n_we1, 2);
        chk("abort_we0", n_we0, 2);
        chk("abort_busy1_end", busy1, 0);

        // Fresh run after the abort.
        clear_rec();
        start_pulse();
        run_cycles(110, 0, 0);
        chk("rerun_done1", done1_cyc, 97);
        chk("rerun_done0", done0_cyc, 89);
        chk("rerun_we1", n_we1, 8);
        chk("rerun_en1", n_en1, 72);
        chk("rerun_last_idx1", {16'd0, we1_idx[7]}, {16'd0, 16'd1, 16'd1, 16'd1});

        // Start held high across DONE->IDLE restarts on the first IDLE cycle.
        clear_rec();
        compute_start = 1'b1;
        @(posedge clk);
        #1;
        run_cycles(100, 0, 0);
        compute_start = 1'b0;
        chk("held_done1", done1_cyc, 97);
        chk("held_busy_c98", busy1_h[98], 0);
        chk("held_busy_c99", busy1_h[99], 1);
        chk("held_clr_c99", clr1_h[99], 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
